// File: rtl/ws2812b_multi_capture.sv
// WS2812B frame decoder: captures the first bytes of each frame into a
// register-readable buffer and forwards the rest of the stream on uo_out[1].
module ws2812b_multi_capture #(
    parameter int CLK_HZ           = 64000000,
    parameter int THRESHOLD_CYCLES = 38,
    parameter int IDLE_US          = 60,
    parameter int BUF_BYTES        = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    localparam int IDLE_CYC = CLK_HZ / 1000000 * IDLE_US;
    localparam int IW = $clog2(IDLE_CYC + 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CYC);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYC - 1);
    localparam logic [7:0]    THR       = 8'(THRESHOLD_CYCLES);
    localparam logic [5:0]    BUF_MAX   = 6'(BUF_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FORWARD} state_t;

    state_t         state_q, state_d;
    logic           din, din_q, rise, fall, bit_ev, bit_val, idle_set;
    logic [7:0]     hi_cnt_q, hi_cnt_d;
    logic [IW-1:0]  low_cnt_q, low_cnt_d;
    logic           idle_q, idle_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [6:0]     shift_q, shift_d;
    logic           byte_valid_q, byte_valid_d;
    logic [7:0]     byte_q, byte_d;
    logic [5:0]     ctrl_q, ctrl_d, shadow_q, shadow_d, frame_ctrl;
    logic [5:0]     need_raw, need;
    logic [3:0]     cap_cnt_q, cap_cnt_d;
    logic           cap_last;
    logic           ready_q, ready_d, overrun_q, overrun_d, short_q, short_d;
    logic [7:0]     frame_cnt_q, frame_cnt_d;
    logic           dout_q, dout_d;
    logic           buf_we, cap_clr, cap_inc, frame_done, short_set, ovr_drop;
    logic [7:0]     buf_q [BUF_BYTES];
    logic [7:0]     buf_d [BUF_BYTES];
    logic [7:0]     buf_rd [12];
    logic           unused_inputs;

    assign din           = ui_in[1];
    assign unused_inputs = ^{ui_in[7:2], ui_in[0], data_in[7:6]};
    assign rise          = din & ~din_q;
    assign fall          = ~din & din_q;
    // A high run already in progress at reset release leaves hi_cnt at 0 and is ignored.
    assign bit_ev        = fall && (hi_cnt_q != 8'd0);
    assign bit_val       = hi_cnt_q > THR;
    assign idle_set      = ~din && (low_cnt_q == IDLE_LAST);

    // While idle is asserted the live CTRL value is the one the next frame will use.
    assign frame_ctrl = idle_q ? ctrl_q : shadow_q;
    assign need_raw   = frame_ctrl[4] ? {frame_ctrl[3:0], 2'b00}
                                      : ({2'b00, frame_ctrl[3:0]} + {1'b0, frame_ctrl[3:0], 1'b0});
    assign need       = (need_raw > BUF_MAX) ? BUF_MAX : need_raw;
    assign cap_last   = ({2'b00, cap_cnt_q} + 6'd1) == need;

    always_comb begin
        hi_cnt_d = hi_cnt_q;
        if (rise)
            hi_cnt_d = 8'd1;
        else if (!din)
            hi_cnt_d = 8'd0;
        else if (hi_cnt_q != 8'd0 && hi_cnt_q != 8'hFF)
            hi_cnt_d = hi_cnt_q + 8'd1;

        low_cnt_d = low_cnt_q;
        if (din)
            low_cnt_d = '0;
        else if (low_cnt_q != IDLE_MAX)
            low_cnt_d = low_cnt_q + IW'(1);

        idle_d = idle_q;
        if (rise)
            idle_d = 1'b0;
        else if (idle_set)
            idle_d = 1'b1;

        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        if (idle_set) begin
            bit_cnt_d = 3'd0;
        end else if (bit_ev) begin
            shift_d   = {shift_q[5:0], bit_val};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_d       = {shift_q, bit_val};
                byte_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (rise) state_d = (need != 6'd0) ? S_CAPTURE : S_FORWARD;
            S_CAPTURE: begin
                if (idle_set)
                    state_d = S_IDLE;
                else if (byte_valid_q && cap_last)
                    state_d = S_FORWARD;
            end
            S_FORWARD: if (idle_set) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        buf_we     = 1'b0;
        cap_clr    = 1'b0;
        cap_inc    = 1'b0;
        frame_done = 1'b0;
        short_set  = 1'b0;
        ovr_drop   = 1'b0;
        dout_d     = (state_d == S_FORWARD) & din;
        case (state_q)
            S_IDLE:    cap_clr = rise;
            S_CAPTURE: begin
                if (idle_set) begin
                    short_set = 1'b1;
                end else if (byte_valid_q) begin
                    cap_inc    = 1'b1;
                    ovr_drop   = frame_ctrl[5] & ready_q;
                    buf_we     = ~(frame_ctrl[5] & ready_q);
                    frame_done = cap_last;
                end
            end
            default: ;
        endcase
    end

    // W1C clears are applied first so a same-cycle set event overrides them.
    always_comb begin
        ctrl_d = ctrl_q;
        if (data_write && address == 4'hC)
            ctrl_d = data_in[5:0];
        shadow_d  = frame_ctrl;
        ready_d   = ready_q;
        overrun_d = overrun_q;
        short_d   = short_q;
        if (data_write && address == 4'hE) begin
            if (data_in[0]) ready_d   = 1'b0;
            if (data_in[1]) overrun_d = 1'b0;
            if (data_in[2]) short_d   = 1'b0;
        end
        if (frame_done)
            ready_d = 1'b1;
        if (ovr_drop || (frame_done && ready_q))
            overrun_d = 1'b1;
        if (short_set)
            short_d = 1'b1;
        frame_cnt_d = frame_done ? frame_cnt_q + 8'd1 : frame_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        if (cap_clr)
            cap_cnt_d = 4'd0;
        else if (cap_inc)
            cap_cnt_d = cap_cnt_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q        <= 1'b1;
            hi_cnt_q     <= 8'd0;
            low_cnt_q    <= '0;
            idle_q       <= 1'b0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 7'd0;
            byte_q       <= 8'd0;
            byte_valid_q <= 1'b0;
            ctrl_q       <= 6'h01;
            shadow_q     <= 6'h01;
            cap_cnt_q    <= 4'd0;
            ready_q      <= 1'b0;
            overrun_q    <= 1'b0;
            short_q      <= 1'b0;
            frame_cnt_q  <= 8'd0;
            dout_q       <= 1'b0;
        end else begin
            din_q        <= din;
            hi_cnt_q     <= hi_cnt_d;
            low_cnt_q    <= low_cnt_d;
            idle_q       <= idle_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            ctrl_q       <= ctrl_d;
            shadow_q     <= shadow_d;
            cap_cnt_q    <= cap_cnt_d;
            ready_q      <= ready_d;
            overrun_q    <= overrun_d;
            short_q      <= short_d;
            frame_cnt_q  <= frame_cnt_d;
            dout_q       <= dout_d;
        end
    end

    genvar gi;
    for (gi = 0; gi < BUF_BYTES; gi++) begin : g_buf
        assign buf_d[gi] = (buf_we && cap_cnt_q == 4'(gi)) ? byte_q : buf_q[gi];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                buf_q[gi] <= 8'h00;
            else
                buf_q[gi] <= buf_d[gi];
        end
    end

    for (gi = 0; gi < 12; gi++) begin : g_rd
        if (gi < BUF_BYTES) begin : g_used
            assign buf_rd[gi] = buf_q[gi];
        end else begin : g_unused
            assign buf_rd[gi] = 8'h00;
        end
    end

    always_comb begin
        data_out = 8'h00;
        case (address)
            4'hC:    data_out = {2'b00, ctrl_q};
            4'hD:    data_out = {4'h0, cap_cnt_q};
            4'hE:    data_out = {5'b00000, short_q, overrun_q, ready_q};
            4'hF:    data_out = frame_cnt_q;
            default: data_out = buf_rd[address];
        endcase
    end

    assign uo_out = {6'b000000, dout_q, 1'b0};

endmodule

// File: doc/ws2812b_multi_capture.md
WS2812B_MULTI_CAPTURE -- requirements
Module: ws2812b_multi_capture

Interface
REQ-001 SHALL have parameter CLK_HZ, default 64000000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter THRESHOLD_CYCLES, default 38, meaning a high pulse longer than this many cycles decodes as 1.
REQ-003 SHALL have parameter IDLE_US, default 60, meaning low time in µs that ends a frame (IDLE_CYC = CLK_HZ/1000000*IDLE_US).
REQ-004 SHALL have parameter BUF_BYTES, default 12, meaning capture buffer depth in bytes (max 12).
REQ-005 SHALL have port clk, input, 1, system clock; single clock domain.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port ui_in, input, 8, where ui_in[1] is serial din (already synchronised).
REQ-008 SHALL have port uo_out, output, 8, where uo_out[1] is serial dout and all other bits are 0.
REQ-009 SHALL have port address, input, 4, register select.
REQ-010 SHALL have port data_write, input, 1, one-cycle write strobe.
REQ-011 SHALL have port data_in, input, 8, write data.
REQ-012 SHALL have port data_out, output, 8, combinational read data for address.

Function
REQ-013 Bit decode SHALL count din-high cycles (saturating at 255); on each falling edge it SHALL emit one bit, value = (count > THRESHOLD_CYCLES).
REQ-014 Bits SHALL be assembled MSB first; byte_valid pulses one cycle after the 8th bit.
REQ-015 Idle SHALL assert after din low for IDLE_CYC consecutive cycles and deassert on the next rising edge; idle SHALL discard any partial byte.
REQ-016 CTRL (0xC) SHALL hold led_count[3:0] (reset 1), rgbw[4] (reset 0), lock[5] (reset 0); bits 7:6 read 0.
REQ-017 need = led_count*(rgbw?4:3), clamped to BUF_BYTES; led_count 0 SHALL mean need=0, i.e. pure pass-through.
REQ-018 CTRL SHALL be sampled into a frame shadow at each idle assertion and at reset; writes mid-frame SHALL affect only the next frame.
REQ-019 FSM states: IDLE, CAPTURE, FORWARD.
REQ-020 IDLE->CAPTURE on first rising edge of din when need>0; IDLE->FORWARD on that edge when need=0.
REQ-021 CAPTURE: byte k (0-based) SHALL be written to buf[k] unless lock=1 and ready=1, in which case bytes are dropped and overrun SHALL be set.
REQ-022 CAPTURE->FORWARD the cycle after byte need-1 completes; ready SHALL set and frame_cnt SHALL increment (wrap 255->0) at that cycle.
REQ-023 A captured frame completing while ready is already 1 SHALL set overrun (whether or not it overwrote).
REQ-024 Idle in CAPTURE SHALL set short and return to IDLE without setting ready or incrementing frame_cnt.
REQ-025 FORWARD: uo_out[1] SHALL equal din delayed one register stage; in IDLE and CAPTURE uo_out[1] SHALL be 0.
REQ-026 FORWARD->IDLE on idle assertion.
REQ-027 Reads: 0x0-0xB SHALL return buf[addr] (0 beyond BUF_BYTES); 0xC CTRL; 0xD bytes captured this/last frame; 0xE STATUS {5'b0, short, overrun, ready}; 0xF frame_cnt.
REQ-028 Write to 0xE SHALL clear each STATUS bit written 1 (W1C); a set event in the same cycle SHALL win.
REQ-029 Writes to 0x0-0xB, 0xD, 0xF SHALL be ignored.
REQ-030 Idle SHALL NOT clear ready, overrun, buffer or frame_cnt.

Reset
REQ-031 On rst_n low, asynchronously: FSM=IDLE, buf=0, STATUS=0, frame_cnt=0, byte count=0, CTRL=8'h01, bit/byte/idle counters=0, uo_out=0.
REQ-032 Reset mid-frame SHALL abandon the frame; the first frame after release SHALL begin only after a rising edge of din.
REQ-033 data_out SHALL reflect reset register values during reset.

Verification
REQ-034 Default CTRL, send bytes 0x12,0x34,0x56 (T0H 26, T1H 51 cycles, period 80) then idle -> buf[0..2]=12,34,56, STATUS=0x01, frame_cnt=1, uo_out[1] low throughout.
REQ-035 CTRL=0x02, send 9 bytes 01..09 -> buf[0..5]=01..06, bytes 07..09 appear on uo_out[1] with 1-cycle delay and identical pulse widths.
REQ-036 CTRL=0x33 (3 LEDs, RGBW, lock), send 12 bytes, skip clearing ready, send 12 more -> buf keeps first frame, STATUS=0x03, frame_cnt=2.
REQ-037 Default CTRL, send 2 bytes then idle -> STATUS=0x04, ready=0, 0xD reads 2; write 0xE=0x04 -> STATUS=0x00.
REQ-038 Write CTRL=0x04 mid-frame -> current frame completes with need=3; next frame uses need=12.
REQ-039 Assert rst_n low mid-byte -> all registers at REQ-031 values immediately; next full frame captures correctly.
